control_hazard_unit: RTL

Registered decode/control unit for the pipelined RV32I core, generalising the combinational decoder into a D→E pipeline stage. Adds optional M-extension decode, load-use hazard detection and a multi-cycle mul/div occupancy FSM. Sits between the decode stage and execute, owning the E-stage control register and the F/D/E stall outputs.

---
 rtl/control_hazard_unit.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_hazard_unit.sv
// Purpose : RV32I D->E control stage with optional M decode, load-use hazard detection
//           and a mul/div E-stage occupancy FSM; owns the E control register and F/D/E stalls.
// Latency : D->E control 1 cycle; ImmSrc_d combinational; M ops hold E for MUL/DIV_CYCLES.
// Backpr. : ext_stall freezes E and the FSM; stall_* are combinational hold requests to F/D/E.
// Ports   : clk/rst (sync, active-high); valid_d, op, funct3, funct7, rs1_d, rs2_d, rd_d from D;
//           flush_e squashes the next E load; *_e registered controls; md_busy = FSM not IDLE.
module control_hazard_unit #(
   parameter int ENABLE_M   = 1,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_d,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic [4:0] rd_d,
   input  logic       flush_e,
   input  logic       ext_stall,
   output logic [2:0] ImmSrc_d,
   output logic       RegWrite_e,
   output logic       MemWrite_e,
   output logic       ALUSrc_e,
   output logic       valid_e,
   output logic       illegal_e,
   output logic [1:0] ResultSrc_e,
   output logic [1:0] Jump_e,
   output logic [2:0] Branch_e,
   output logic [4:0] rd_e,
   output logic [4:0] ALUControl_e,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       md_busy
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   // Immediate formats seen by the D-stage extender.
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   logic       w_reg_write, w_mem_write, w_alu_src, w_illegal;
   logic       w_is_md, w_use_rs1, w_use_rs2;
   logic [1:0] w_result_src, w_jump;
   logic [2:0] w_branch, w_imm_src;
   logic [4:0] w_alu_ctrl;
   logic       w_load_use, w_lu_stall, w_md_hold, w_advance, w_load_md;
   logic [CW-1:0] w_md_load;

   // funct3 -> base ALU code; alt selects sub/sra.
   function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
      logic [4:0] r;
      case (f3)
         3'b000:  r = alt ? 5'b00001 : 5'b00000;
         3'b001:  r = 5'b00101;
         3'b010:  r = 5'b01000;
         3'b011:  r = 5'b01001;
         3'b100:  r = 5'b00100;
         3'b101:  r = alt ? 5'b00110 : 5'b00111;
         3'b110:  r = 5'b00011;
         default: r = 5'b00010;
      endcase
      return r;
   endfunction

   // ---------------- D-stage decode ----------------
   always_comb begin
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_result_src = 2'b00;
      w_jump       = 2'b00;
      w_branch     = 3'b000;
      w_alu_ctrl   = 5'b00000;
      w_imm_src    = IMM_I;
      w_illegal    = 1'b0;
      w_is_md      = 1'b0;
      w_use_rs1    = 1'b1;
      w_use_rs2    = 1'b0;
      case (op)
         OP_R: begin
            w_reg_write = 1'b1;
            w_use_rs2   = 1'b1;
            if (funct7 == 7'b0000001) begin
               if (ENABLE_M != 0) begin
                  w_is_md    = 1'b1;
                  w_alu_ctrl = {2'b10, funct3};
               end else begin
                  w_illegal  = 1'b1;
               end
            end else begin
               w_alu_ctrl = alu_base(funct3, funct7[5]);
            end
         end
         OP_I: begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            // Only shifts use funct7[5]; addi never becomes sub.
            w_alu_ctrl  = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
         end
         OP_LD: begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_result_src = 2'b01;
         end
         OP_JALR: begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_result_src = 2'b10;
            w_jump       = 2'b10;
         end
         OP_S: begin
            w_mem_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm_src   = IMM_S;
            w_use_rs2   = 1'b1;
         end
         OP_B: begin
            w_imm_src  = IMM_B;
            w_alu_ctrl = 5'b00001;
            w_use_rs2  = 1'b1;
            case (funct3)
               3'b000:  w_branch = 3'b001;
               3'b001:  w_branch = 3'b010;
               3'b010,
               3'b011:  w_illegal = 1'b1;
               default: w_branch = funct3;
            endcase
         end
         OP_LUI: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'b11;
            w_imm_src    = IMM_U;
            w_use_rs1    = 1'b0;
         end
         OP_JAL: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'b10;
            w_jump       = 2'b01;
            w_imm_src    = IMM_J;
            w_use_rs1    = 1'b0;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   assign ImmSrc_d = w_imm_src;

   // ---------------- hazards ----------------
   assign w_load_use = valid_e && (ResultSrc_e == 2'b01) && (rd_e != 5'd0) &&
                       ((w_use_rs1 && (rs1_d == rd_e)) || (w_use_rs2 && (rs2_d == rd_e)));
   // A flushed D slot is discarded anyway, so the load-use stall is not needed.
   assign w_lu_stall = w_load_use && !flush_e;
   assign w_md_hold  = (r_state == MD_BUSY) && (r_cnt != '0);
   assign w_advance  = !ext_stall && !w_md_hold;
   assign w_load_md  = valid_d && w_is_md && !w_illegal && !flush_e && !w_load_use;
   assign w_md_load  = funct3[2] ? DIV_LOAD : MUL_LOAD;

   assign stall_e = !rst && w_md_hold;
   assign stall_f = !rst && (w_md_hold || w_lu_stall);
   assign stall_d = stall_f;
   assign md_busy = (r_state == MD_BUSY);

   // ---------------- mul/div occupancy FSM ----------------
   // BUSY lasts N-1 cycles (all stalled); the last E cycle of the op is spent in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (ext_stall) begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
      end else if (w_md_hold) begin
         w_cnt_nxt = r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            w_state_nxt = IDLE;
         end
      end else begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         if (w_load_md && (w_md_load != '0)) begin
            w_state_nxt = MD_BUSY;
            w_cnt_nxt   = w_md_load;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ---------------- E-stage control register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite_e   <= 1'b0;
         MemWrite_e   <= 1'b0;
         ALUSrc_e     <= 1'b0;
         valid_e      <= 1'b0;
         illegal_e    <= 1'b0;
         ResultSrc_e  <= 2'b00;
         Jump_e       <= 2'b00;
         Branch_e     <= 3'b000;
         rd_e         <= 5'd0;
         ALUControl_e <= 5'd0;
      end else if (w_advance) begin
         if (flush_e || w_load_use || !valid_d || w_illegal) begin
            RegWrite_e   <= 1'b0;
            MemWrite_e   <= 1'b0;
            ALUSrc_e     <= 1'b0;
            valid_e      <= 1'b0;
            // Only a real, unsquashed instruction can report illegal.
            illegal_e    <= valid_d && w_illegal && !flush_e && !w_load_use;
            ResultSrc_e  <= 2'b00;
            Jump_e       <= 2'b00;
            Branch_e     <= 3'b000;
            rd_e         <= 5'd0;
            ALUControl_e <= 5'd0;
         end else begin
            RegWrite_e   <= w_reg_write;
            MemWrite_e   <= w_mem_write;
            ALUSrc_e     <= w_alu_src;
            valid_e      <= 1'b1;
            illegal_e    <= 1'b0;
            ResultSrc_e  <= w_result_src;
            Jump_e       <= w_jump;
            Branch_e     <= w_branch;
            rd_e         <= rd_d;
            ALUControl_e <= w_alu_ctrl;
         end
      end
   end

endmodule
